// File: rtl/store_buf_pkg.sv
// Shared types and helpers for the store buffer: RISC-V store/load size
// encodings, the buffered entry layout and the access-size decode.
package store_buf_pkg;

  localparam int SB_DATA_WIDTH = 32;

  // Store sizes (funct3 of sb/sh/sw)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Load sizes (funct3 of lb/lh/lw/lbu/lhu)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [SB_DATA_WIDTH-1:0] addr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [2:0]               funct3;
  } sb_entry_t;

  // Access size in bytes; signed/unsigned load variants share the store sizes.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: return 3'd1;
      F3_LH, F3_LHU: return 3'd2;
      default:       return 3'd4;
    endcase
  endfunction

  // Only sb, sh and sw are real stores worth buffering.
  function automatic logic is_store_f3(input logic [2:0] funct3);
    return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_buffer_span_overlap.sv
// Word-granular overlap test between two byte accesses. Each access covers
// at most two consecutive words, so comparing first/last word indices
// pairwise is exact and stays correct across address wrap-around.
module span_overlap
  import store_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_addr,
  input  logic [2:0]            a_funct3,
  input  logic [DATA_WIDTH-1:0] b_addr,
  input  logic [2:0]            b_funct3,
  output logic                  overlap
);

  localparam int WW = DATA_WIDTH - 2;

  logic [2:0]    a_end_off, b_end_off;
  logic          a_cross, b_cross;
  logic [WW-1:0] a_first, a_last, b_first, b_last;

  // Offset of the last byte inside the first word; above 3 means the access
  // spills into the next word.
  assign a_end_off = {1'b0, a_addr[1:0]} + (size_bytes(a_funct3) - 3'd1);
  assign b_end_off = {1'b0, b_addr[1:0]} + (size_bytes(b_funct3) - 3'd1);
  assign a_cross   = (a_end_off > 3'd3);
  assign b_cross   = (b_end_off > 3'd3);

  assign a_first = a_addr[DATA_WIDTH-1:2];
  assign b_first = b_addr[DATA_WIDTH-1:2];
  assign a_last  = a_first + WW'(a_cross);
  assign b_last  = b_first + WW'(b_cross);

  assign overlap = (a_first == b_first) || (a_first == b_last) ||
                   (a_last  == b_first) || (a_last  == b_last);

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and the data memory.
// Stores are queued in order and drained one per cycle from the head entry;
// loads overlapping any pending store raise ld_hazard.
// Optional macro STORE_BUF_FWD_EN adds word store-to-load forwarding
// (ld_fwd_valid / ld_fwd_data) for an lw fully covered by the youngest
// overlapping sw.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [DATA_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_funct3,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic                  mem_ready,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic                  ld_hazard,
  output logic                  empty
`ifdef STORE_BUF_FWD_EN
  ,
  output logic                  ld_fwd_valid,
  output logic [DATA_WIDTH-1:0] ld_fwd_data
`endif
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  sb_entry_t          entries [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count;

  logic               push, enq, pop;
  logic [DEPTH-1:0]   overlap_vec, hit;
  logic               any_hit;

  // Handshake: a full buffer refuses stores even while it is draining.
  assign st_ready = (count != FULL_COUNT);
  assign push     = st_valid && st_ready;
  assign enq      = push && is_store_f3(st_funct3);
  assign empty    = (count == '0);
  assign mem_wen  = !empty && mem_ready;
  assign pop      = mem_wen;

  assign mem_addr   = empty ? '0 : entries[head].addr;
  assign mem_wdata  = empty ? '0 : entries[head].data;
  assign mem_funct3 = empty ? '0 : entries[head].funct3;

  // Entry payload write at the tail.
  // NOTE: payload storage has no reset; valid_q and count gate every read,
  // so only the control state needs clearing.
  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
  end

  // Pointer, occupancy and valid-bit bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every update
  // reads the pre-edge values of head/tail/count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        head          <= head + 1'b1;
        valid_q[head] <= 1'b0;
      end
      if (enq) begin
        tail          <= tail + 1'b1;
        valid_q[tail] <= 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // One overlap comparator per entry against the current load.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    span_overlap #(.DATA_WIDTH(DATA_WIDTH)) u_span_overlap (
      .a_addr   (entries[i].addr),
      .a_funct3 (entries[i].funct3),
      .b_addr   (ld_addr),
      .b_funct3 (ld_funct3),
      .overlap  (overlap_vec[i])
    );
  end

  assign hit     = valid_q & overlap_vec;
  assign any_hit = |hit;

`ifdef STORE_BUF_FWD_EN
  logic [PTR_W-1:0] young_idx;
  logic             fwd_ok;

  // Find the youngest overlapping entry by walking from head (oldest) forward.
  // NOTE: defaults first keep this block free of inferred latches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    young_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (hit[idx]) young_idx = idx;
    end
  end

  // An aligned lw fully covered by an aligned sw to the same word can take
  // the store data directly; the sw overwrites every byte of that word.
  assign fwd_ok = any_hit &&
                  (entries[young_idx].funct3 == F3_SW) &&
                  (entries[young_idx].addr[1:0] == 2'b00) &&
                  (entries[young_idx].addr[DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2]) &&
                  (ld_funct3 == F3_LW) &&
                  (ld_addr[1:0] == 2'b00);

  assign ld_fwd_valid = ld_valid && fwd_ok;
  assign ld_fwd_data  = ld_fwd_valid ? entries[young_idx].data : '0;
  assign ld_hazard    = ld_valid && any_hit && !fwd_ok;
`else
  assign ld_hazard    = ld_valid && any_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit).
module tb_store_buffer;
  import store_buf_pkg::*;

  logic        clk, rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_hazard, empty;
`ifdef STORE_BUF_FWD_EN
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  store_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_funct3  (st_funct3),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_ready  (mem_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_funct3  (ld_funct3),
    .ld_hazard  (ld_hazard),
    .empty      (empty)
`ifdef STORE_BUF_FWD_EN
    ,
    .ld_fwd_valid (ld_fwd_valid),
    .ld_fwd_data  (ld_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: record every accepted write on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_wen === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
    tick();
    st_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    mem_ready = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
    repeat (2) tick();

    // Reset state
    check("rst_st_ready",   32'(st_ready),   32'd1);
    check("rst_mem_wen",    32'(mem_wen),    32'd0);
    check("rst_mem_addr",   mem_addr,        32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_mem_funct3", 32'(mem_funct3), 32'd0);
    check("rst_ld_hazard",  32'(ld_hazard),  32'd0);
    check("rst_empty",      32'(empty),      32'd1);
    rst_n = 1'b1;
    tick();

    // Reset mid-drain discards pending stores
    mem_ready = 1'b0;
    push(32'h100, 32'h1, F3_SW);
    push(32'h104, 32'h2, F3_SW);
    push(32'h108, 32'h3, F3_SW);
    #1;
    check("mid_empty",    32'(empty),   32'd0);
    check("mid_mem_wen",  32'(mem_wen), 32'd0);
    check("mid_head",     mem_addr,     32'h100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty",   32'(empty),   32'd1);
    check("mid_rst_mem_wen", 32'(mem_wen), 32'd0);
    check("mid_rst_addr",    mem_addr,     32'd0);
    #1 rst_n = 1'b1;
    wq_addr.delete(); wq_data.delete();
    mem_ready = 1'b1;
    repeat (3) tick();
    check("mid_no_writes", 32'(wq_addr.size()), 32'd0);
    check("mid_empty_after", 32'(empty), 32'd1);

    // Fill to full, then drain in order
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h10000 + 32'(4 * i), 32'hA000_0000 + 32'(i), F3_SW);
      check($sformatf("fill_st_ready_%0d", i), 32'(st_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    check("full_empty", 32'(empty), 32'd0);
    wq_addr.delete(); wq_data.delete();
    mem_ready = 1'b1;
    repeat (4) tick();
    check("drain_count", 32'(wq_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq_addr.size()) begin
        check($sformatf("drain_addr_%0d", i), wq_addr[i], 32'h10000 + 32'(4 * i));
        check($sformatf("drain_data_%0d", i), wq_data[i], 32'hA000_0000 + 32'(i));
      end
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push/pop at count=2 with pointer wrap
    mem_ready = 1'b0;
    wq_addr.delete(); wq_data.delete();
    push(32'h200, 32'h1000_0000, F3_SW);
    push(32'h204, 32'h1000_0001, F3_SW);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_valid  = 1'b1;
      st_addr   = 32'h208 + 32'(4 * i);
      st_data   = 32'h1000_0002 + 32'(i);
      st_funct3 = F3_SW;
      #1;
      check($sformatf("pp_st_ready_%0d", i), 32'(st_ready), 32'd1);
      check($sformatf("pp_mem_wen_%0d", i),  32'(mem_wen),  32'd1);
      tick();
    end
    st_valid = 1'b0;
    check("pp_head_e", mem_addr, 32'h210);
    tick();
    check("pp_head_f", mem_addr, 32'h214);
    tick();
    check("pp_empty", 32'(empty), 32'd1);
    check("pp_write_count", 32'(wq_addr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq_addr.size()) begin
        check($sformatf("pp_addr_%0d", i), wq_addr[i], 32'h200 + 32'(4 * i));
        check($sformatf("pp_data_%0d", i), wq_data[i], 32'h1000_0000 + 32'(i));
      end
    end

    // Overlap detection: sh at 0x10003 covers words 0x10000 and 0x10004
    mem_ready = 1'b0;
    push(32'h10003, 32'h1234, F3_SH);
    ld_valid = 1'b1; ld_addr = 32'h10004; ld_funct3 = F3_LB;
    #1 check("haz_lb_10004", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h10008;
    #1 check("haz_lb_10008", 32'(ld_hazard), 32'd0);
    ld_addr = 32'h10000;
    #1 check("haz_lb_10000", 32'(ld_hazard), 32'd1);
    ld_valid = 1'b0; ld_addr = 32'h10004;
    #1 check("haz_no_ld_valid", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b1; mem_ready = 1'b1;
    #1 check("haz_pop_wen", 32'(mem_wen), 32'd1);
    check("haz_during_pop", 32'(ld_hazard), 32'd1);
    tick();
    check("haz_after_pop", 32'(ld_hazard), 32'd0);
    ld_valid = 1'b0;

    // Invalid store size: handshake completes, nothing enqueued
    wq_addr.delete(); wq_data.delete();
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h77; st_funct3 = 3'b011;
    #1 check("inv_st_ready", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    check("inv_empty",   32'(empty),   32'd1);
    check("inv_mem_wen", 32'(mem_wen), 32'd0);
    tick();
    check("inv_no_write", 32'(wq_addr.size()), 32'd0);

    // Word forwarding (or plain hazard when the feature is absent)
    mem_ready = 1'b0;
    push(32'h10010, 32'hDEADBEEF, F3_SW);
    ld_valid = 1'b1; ld_addr = 32'h10010; ld_funct3 = F3_LW;
`ifdef STORE_BUF_FWD_EN
    #1;
    check("fwd_valid_lw", 32'(ld_fwd_valid), 32'd1);
    check("fwd_data_lw",  ld_fwd_data,       32'hDEADBEEF);
    check("fwd_haz_lw",   32'(ld_hazard),    32'd0);
    ld_funct3 = F3_LH;
    #1;
    check("fwd_haz_lh",   32'(ld_hazard),    32'd1);
    check("fwd_valid_lh", 32'(ld_fwd_valid), 32'd0);
    ld_valid = 1'b0;
    push(32'h10012, 32'h55, F3_SB);
    ld_valid = 1'b1; ld_funct3 = F3_LW;
    #1;
    check("fwd_young_sb_haz",   32'(ld_hazard),    32'd1);
    check("fwd_young_sb_valid", 32'(ld_fwd_valid), 32'd0);
`else
    #1 check("nofwd_haz_lw", 32'(ld_hazard), 32'd1);
`endif
    ld_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (3) tick();
    check("final_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the pipeline MEM stage and the byte-addressed data memory.
- Accepts sb/sh/sw stores from the pipeline and drains one per cycle into the memory write port. The memory's wen, addr, write_data and funct3 are driven from the head entry.
- Flags loads that overlap a pending store so the hazard unit can stall the load until that store has drained.

Parameters:
- DATA_WIDTH, 32, width of address and data.
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  pipeline presents a store.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  DATA_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data; low bytes used for sb/sh.
- st_funct3  in  3  000 sb, 001 sh, 010 sw.
- mem_wen  out  1  write strobe to data memory.
- mem_addr  out  DATA_WIDTH  head entry address.
- mem_wdata  out  DATA_WIDTH  head entry data.
- mem_funct3  out  3  head entry store size.
- mem_ready  in  1  memory accepts the write this cycle; tie high if the memory never stalls.
- ld_valid  in  1  MEM stage is executing a load.
- ld_addr  in  DATA_WIDTH  load byte address.
- ld_funct3  in  3  load size (000/100 byte, 001/101 half, 010 word).
- ld_hazard  out  1  load overlaps a pending entry; pipeline must stall.
- empty  out  1  no pending stores; used for fence and ecall drain.

Behaviour:
- Reset (async, rst_n=0):
  - head, tail and count cleared to 0; all entries invalid; pending stores discarded.
  - Outputs: st_ready=1, mem_wen=0, mem_addr=0, mem_wdata=0, mem_funct3=0, ld_hazard=0, empty=1.
- Storage: circular array of {addr, data, funct3}. tail is the write pointer, head the read pointer; both wrap modulo DEPTH. count ranges 0..DEPTH.
- Push: fires when st_valid && st_ready; writes the entry at tail on posedge.
  - st_ready = (count != DEPTH). A full buffer does not accept a store in the same cycle it pops.
- Invalid size: st_funct3 not in {000,001,010} is accepted (handshake completes) but not enqueued.
- Drain:
  - mem_wen = (count != 0) && mem_ready.
  - mem_addr, mem_wdata and mem_funct3 are driven combinationally from the head entry. They are 0 when empty.
  - Pop fires when mem_wen=1: head advances on posedge. Memory samples the write on its negedge within the same cycle.
- Latency: a store pushed in cycle N appears on mem_* in cycle N+1 at the earliest. Stores drain strictly in order.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Overlap check, per valid entry:
  - Entry span is word indices addr[31:2] .. (addr+size-1)[31:2], where size is 1, 2 or 4 from funct3.
  - Load span is computed the same way from ld_addr and ld_funct3.
  - Overlap is any equal word index between the two spans (word granularity).
- ld_hazard = ld_valid && any overlapping valid entry. It is combinational.
  - A store being pushed in the same cycle is not checked; the pipeline ordering guarantees the load's check falls at least one cycle later.
- The entry being popped in the current cycle still counts for ld_hazard.
- empty = (count == 0).

Optional Feature:
- STORE_BUF_FWD_EN, defined: adds output ld_fwd_valid (1 bit) and ld_fwd_data (DATA_WIDTH).
  - Condition: the youngest overlapping entry is an sw at word-aligned addr equal to ld_addr word, and the load is an lw.
  - When the condition holds: ld_fwd_valid=1, ld_fwd_data = that entry's data, ld_hazard=0.
  - All other overlaps still raise ld_hazard.
- STORE_BUF_FWD_EN, undefined: those ports are absent and every overlap raises ld_hazard.

Decomposition:
- Package store_buf_pkg:
  - Store funct3 constants F3_SB, F3_SH, F3_SW; load funct3 constants.
  - Typedef sb_entry_t {addr, data, funct3}.
  - Function size_bytes(funct3).
- Sub-module span_overlap: combinational compare of two (addr, funct3) spans; one instance per entry.

Test Plan:
- Reset mid-drain: fill with 3 stores, deassert mem_ready, pulse rst_n low -> empty=1, mem_wen=0. The 3 stores never reach memory.
- Fill then drain: 4 sw to 0x10000..0x1000C with mem_ready=0 -> st_ready=0 after the 4th. Raise mem_ready -> memory receives 0x10000, 0x10004, 0x10008, 0x1000C in order, one per cycle.
- Simultaneous push and pop at count=2 -> count stays 2. Pointers wrap past DEPTH-1 with no lost or duplicated entry.
- sh to 0x10003 pending, lb at 0x10004 -> ld_hazard=1 (the halfword straddles into word 0x10004). lb at 0x10008 -> ld_hazard=0.
- st_funct3=011 with st_valid=1 -> handshake completes, count unchanged, no memory write.
- STORE_BUF_FWD_EN: sw 0xDEADBEEF to 0x10010 pending, lw 0x10010 -> ld_fwd_valid=1, ld_fwd_data=0xDEADBEEF, ld_hazard=0. lh 0x10010 -> ld_hazard=1.
